// File: rtl/player_ctrl_pkg.sv
// Shared definitions for the player car sequencer: state encodings, car geometry
// and the saturating speed-step helper.
package player_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_RUN       = 3'd2,
        ST_CRASH     = 3'd3,
        ST_RESPAWN   = 3'd4,
        ST_OVER      = 3'd5
    } state_t;

    localparam int CAR_W       = 16;
    localparam int ROAD_X_MAX  = 240;
    localparam int CAR_X_RESET = 120;
    localparam int CAR_Y       = 440;

    localparam int SPEED_W = 3;
    localparam int LIVES_W = 2;
    localparam int TIMER_W = 8;
    localparam int ACCEL_W = 3;

    // One accel-counter step: up saturates at ceiling, down saturates at zero.
    function automatic logic [SPEED_W-1:0] speed_step(
        input logic [SPEED_W-1:0] cur,
        input logic               up,
        input logic               step,
        input logic [SPEED_W-1:0] ceiling
    );
        if (!step) begin
            return cur;
        end
        if (up) begin
            return (cur >= ceiling) ? ceiling : cur + 1'b1;
        end
        return (cur == '0) ? '0 : cur - 1'b1;
    endfunction

endpackage

// File: rtl/player_ctrl_frame_timer.sv
// Frame counter shared by all timed states; done flags the last frame of a
// state of the given length, qualified by the frame tick.
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         tick,
    input  logic [W-1:0] length,
    output logic [W-1:0] count,
    output logic         done
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
    assign done  = tick && (count_reg == length - 1'b1);

endmodule

// File: rtl/player_ctrl.sv
// Game-state sequencer for the player car: turns level buttons into per-frame
// move strobes and runs countdown / run / crash / respawn / game-over.
module player_ctrl
    import player_ctrl_pkg::*;
#(
    parameter int START_FRAMES   = 120,
    parameter int CRASH_FRAMES   = 90,
    parameter int RESPAWN_FRAMES = 60,
    parameter int LIVES          = 3,
    parameter int MAX_SPEED      = 7,
    parameter int ACCEL_FRAMES   = 8,
    parameter int X_MAX          = ROAD_X_MAX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               left_btn,
    input  logic               right_btn,
    input  logic               accel_btn,
    input  logic               collision,
    input  logic [7:0]         car_x,
    output logic               move_left,
    output logic               move_right,
    output logic               recenter,
    output logic [SPEED_W-1:0] speed,
    output logic [LIVES_W-1:0] lives,
    output logic [2:0]         state,
    output logic               car_visible,
    output logic               game_over
);

    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
    localparam logic [SPEED_W-1:0] SPEED_TOP  = SPEED_W'(MAX_SPEED);
    localparam logic [ACCEL_W-1:0] ACCEL_LAST = ACCEL_W'(ACCEL_FRAMES - 1);
    localparam logic [7:0]         EDGE_R     = 8'(X_MAX);

    state_t               state_reg;
    state_t               state_next;
    logic [LIVES_W-1:0]   lives_reg;
    logic [SPEED_W-1:0]   speed_reg;
    logic [SPEED_W-1:0]   speed_next;
    logic [ACCEL_W-1:0]   accel_cnt_reg;
    logic                 hit_reg;
    logic                 move_left_reg;
    logic                 move_right_reg;
    logic                 recenter_reg;
    logic                 car_visible_reg;
    logic                 game_over_reg;

    logic [TIMER_W-1:0]   timer_len;
    logic [TIMER_W-1:0]   timer_count;
    logic                 timer_done;
    logic                 timer_clear;

    logic                 go_left;
    logic                 go_right;
    logic                 edge_crash;
    logic                 crash_now;
    logic                 steer_en;
    logic                 accel_step;
    logic                 blink_off;

    always_comb begin
        go_left    = left_btn & ~right_btn;
        go_right   = right_btn & ~left_btn;
        edge_crash = ((car_x == 8'd0) && go_left) || ((car_x == EDGE_R) && go_right);
        crash_now  = hit_reg | collision | edge_crash;
        steer_en   = (state_reg == ST_RUN) || (state_reg == ST_RESPAWN);
        accel_step = (accel_cnt_reg == ACCEL_LAST);
        speed_next = speed_step(speed_reg, accel_btn, accel_step, SPEED_TOP);
        // Bit 3 of (count + 1): the blink phase the count will have after this tick.
        blink_off  = timer_count[3] ^ (&timer_count[2:0]);
    end

    always_comb begin
        timer_len = '0;
        case (state_reg)
            ST_COUNTDOWN: timer_len = TIMER_W'(START_FRAMES);
            ST_CRASH:     timer_len = TIMER_W'(CRASH_FRAMES);
            ST_RESPAWN:   timer_len = TIMER_W'(RESPAWN_FRAMES);
            default:      timer_len = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        if (frame_tick) begin
            case (state_reg)
                ST_IDLE, ST_OVER: if (start_btn) state_next = ST_COUNTDOWN;
                ST_COUNTDOWN:     if (timer_done) state_next = ST_RUN;
                ST_RUN:           if (crash_now) state_next = ST_CRASH;
                ST_CRASH: begin
                    if (timer_done) begin
                        state_next = (lives_reg == '0) ? ST_OVER : ST_RESPAWN;
                    end
                end
                ST_RESPAWN:       if (timer_done) state_next = ST_RUN;
                default:          state_next = ST_IDLE;
            endcase
        end
        timer_clear = (state_next != state_reg);
    end

    frame_timer #(
        .W(TIMER_W)
    ) u_frame_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .tick   (frame_tick),
        .length (timer_len),
        .count  (timer_count),
        .done   (timer_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= ST_IDLE;
            lives_reg       <= LIVES_INIT;
            speed_reg       <= '0;
            accel_cnt_reg   <= '0;
            hit_reg         <= 1'b0;
            move_left_reg   <= 1'b0;
            move_right_reg  <= 1'b0;
            recenter_reg    <= 1'b0;
            car_visible_reg <= 1'b1;
            game_over_reg   <= 1'b0;
        end else begin
            move_left_reg  <= 1'b0;
            move_right_reg <= 1'b0;
            recenter_reg   <= 1'b0;
            // A hit between ticks is held until the tick that consumes it.
            hit_reg        <= frame_tick ? 1'b0 : (hit_reg | collision);
            if (frame_tick) begin
                state_reg       <= state_next;
                accel_cnt_reg   <= accel_cnt_reg + 1'b1;
                game_over_reg   <= (state_next == ST_OVER);
                car_visible_reg <= 1'b1;
                speed_reg       <= '0;
                if (steer_en) begin
                    move_left_reg  <= go_left;
                    move_right_reg <= go_right;
                end
                case (state_reg)
                    ST_IDLE, ST_OVER: begin
                        if (start_btn) begin
                            recenter_reg <= 1'b1;
                            lives_reg    <= LIVES_INIT;
                        end
                    end
                    ST_RUN: begin
                        if (crash_now) begin
                            lives_reg <= (lives_reg == '0) ? '0 : lives_reg - 1'b1;
                        end else begin
                            speed_reg <= speed_next;
                        end
                    end
                    ST_CRASH: begin
                        if (timer_done && (lives_reg != '0)) begin
                            recenter_reg <= 1'b1;
                        end
                    end
                    ST_RESPAWN: begin
                        speed_reg <= speed_next;
                        if (!timer_done) begin
                            car_visible_reg <= ~blink_off;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    a_count_in_range: assert property (@(posedge clk) disable iff (!reset)
        (state_reg inside {ST_COUNTDOWN, ST_CRASH, ST_RESPAWN}) |-> (timer_count < timer_len));

    assign move_left   = move_left_reg;
    assign move_right  = move_right_reg;
    assign recenter    = recenter_reg;
    assign speed       = speed_reg;
    assign lives       = lives_reg;
    assign state       = state_reg;
    assign car_visible = car_visible_reg;
    assign game_over   = game_over_reg;

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: stimulus queues the expected outputs for each
// frame tick or reset cycle, a monitor pops and compares when the DUT updates.
module tb_player_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic [1:0] lv;
        logic [2:0] sp;
        logic       vis;
        logic       over;
        logic       ml;
        logic       mr;
        logic       rc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start_btn = 1'b0;
    logic       left_btn = 1'b0;
    logic       right_btn = 1'b0;
    logic       accel_btn = 1'b0;
    logic       collision = 1'b0;
    logic [7:0] car_x = 8'd120;
    logic       move_left, move_right, recenter, car_visible, game_over;
    logic [2:0] speed, state;
    logic [1:0] lives;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    passes = 0;
    int    tick_n = 0;

    logic [2:0] e_st = 3'd0;
    logic [1:0] e_lv = 2'd3;
    logic [2:0] e_sp = 3'd0;
    logic       e_vis = 1'b1;
    logic       e_over = 1'b0;

    exp_t  mon_e, mon_a;
    string mon_n;
    logic  mon_tick;

    player_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .start_btn   (start_btn),
        .left_btn    (left_btn),
        .right_btn   (right_btn),
        .accel_btn   (accel_btn),
        .collision   (collision),
        .car_x       (car_x),
        .move_left   (move_left),
        .move_right  (move_right),
        .recenter    (recenter),
        .speed       (speed),
        .lives       (lives),
        .state       (state),
        .car_visible (car_visible),
        .game_over   (game_over)
    );

    always #5 clk = ~clk;

    // Monitor: the DUT presents new outputs after every tick edge and every reset edge.
    always begin
        @(posedge clk);
        if (reset !== 1'b1 || frame_tick === 1'b1) begin
            mon_tick = (reset === 1'b1);
            #1;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL underflow: DUT update with no expected entry, got state=%0d", state);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                mon_a = {state, lives, speed, car_visible, game_over, move_left, move_right, recenter};
                if (mon_a === mon_e) begin
                    passes++;
                end else begin
                    $display("FAIL %s: got st=%0d lv=%0d sp=%0d vis=%b over=%b ml=%b mr=%b rc=%b, want st=%0d lv=%0d sp=%0d vis=%b over=%b ml=%b mr=%b rc=%b",
                             mon_n, mon_a.st, mon_a.lv, mon_a.sp, mon_a.vis, mon_a.over, mon_a.ml, mon_a.mr, mon_a.rc,
                             mon_e.st, mon_e.lv, mon_e.sp, mon_e.vis, mon_e.over, mon_e.ml, mon_e.mr, mon_e.rc);
                end
            end
            if (mon_tick) begin
                @(posedge clk);
                #1;
                checks++;
                if ({move_left, move_right, recenter} === 3'b000) begin
                    passes++;
                end else begin
                    $display("FAIL pulse_width after %s: got ml=%b mr=%b rc=%b, want 000",
                             mon_n, move_left, move_right, recenter);
                end
            end
        end
    end

    task automatic frame(input logic ml, input logic mr, input logic rc, input logic col, input string nm);
        exp_q.push_back({e_st, e_lv, e_sp, e_vis, e_over, ml, mr, rc});
        name_q.push_back(nm);
        @(negedge clk);
        frame_tick = 1'b1;
        collision  = col;
        @(negedge clk);
        frame_tick = 1'b0;
        collision  = 1'b0;
        repeat (4) @(negedge clk);
        tick_n++;
        $display("frame %0d %s: st=%0d lv=%0d sp=%0d vis=%b", tick_n, nm, state, lives, speed, car_visible);
    endtask

    task automatic pulse_collision();
        @(negedge clk);
        collision = 1'b1;
        @(negedge clk);
        collision = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({3'd0, 2'd3, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
            name_q.push_back(nm);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset  = 1'b1;
        tick_n = 0;
        e_st = 3'd0; e_lv = 2'd3; e_sp = 3'd0; e_vis = 1'b1; e_over = 1'b0;
        $display("reset %s released", nm);
    endtask

    // Expected speed for the upcoming tick in RUN/RESPAWN: steps on every 8th tick.
    task automatic upd_speed();
        if (((tick_n + 1) % 8) == 0) begin
            if (accel_btn) e_sp = (e_sp == 3'd7) ? 3'd7 : e_sp + 3'd1;
            else           e_sp = (e_sp == 3'd0) ? 3'd0 : e_sp - 3'd1;
        end
    endtask

    task automatic countdown(input string nm);
        for (int i = 1; i <= 120; i++) begin
            if (i == 120) e_st = 3'd2;
            frame(1'b0, 1'b0, 1'b0, 1'b0, nm);
        end
    endtask

    task automatic crash_wait(input logic [2:0] after, input logic rc_end, input string nm);
        for (int i = 1; i <= 90; i++) begin
            if (i == 90) begin
                e_st = after;
                e_over = (after == 3'd5);
            end
            frame(1'b0, 1'b0, (i == 90) ? rc_end : 1'b0, 1'b0, nm);
        end
    endtask

    task automatic respawn(input logic with_hits, input string nm);
        for (int i = 1; i <= 60; i++) begin
            right_btn = (i == 30);
            if (with_hits && (i == 5 || i == 20 || i == 60)) pulse_collision();
            upd_speed();
            if (i == 60) begin
                e_st = 3'd2;
                e_vis = 1'b1;
            end else begin
                e_vis = (((i / 8) % 2) == 0);
            end
            frame(1'b0, (i == 30), 1'b0, with_hits && (i == 40), nm);
        end
        right_btn = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget, %0d entries pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset("reset_init");
        frame(1'b0, 1'b0, 1'b0, 1'b0, "idle_hold");

        start_btn = 1'b1; left_btn = 1'b1;
        e_st = 3'd1; e_lv = 2'd3;
        frame(1'b0, 1'b0, 1'b1, 1'b0, "start_from_idle");
        start_btn = 1'b0;
        countdown("countdown_left_held");
        left_btn = 1'b0;

        left_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin upd_speed(); frame(1'b1, 1'b0, 1'b0, 1'b0, "steer_left"); end
        right_btn = 1'b1;
        for (int i = 0; i < 3; i++) begin upd_speed(); frame(1'b0, 1'b0, 1'b0, 1'b0, "steer_both"); end
        left_btn = 1'b0;
        for (int i = 0; i < 2; i++) begin upd_speed(); frame(1'b0, 1'b1, 1'b0, 1'b0, "steer_right"); end
        right_btn = 1'b0;

        accel_btn = 1'b1;
        for (int i = 0; i < 64; i++) begin upd_speed(); frame(1'b0, 1'b0, 1'b0, 1'b0, "accel_up"); end
        accel_btn = 1'b0;
        for (int i = 0; i < 64; i++) begin upd_speed(); frame(1'b0, 1'b0, 1'b0, 1'b0, "accel_down"); end
        accel_btn = 1'b1;
        for (int i = 0; i < 16; i++) begin upd_speed(); frame(1'b0, 1'b0, 1'b0, 1'b0, "accel_pre_crash"); end
        accel_btn = 1'b0;

        pulse_collision();
        e_st = 3'd3; e_lv = 2'd2; e_sp = 3'd0;
        frame(1'b0, 1'b0, 1'b0, 1'b0, "crash_collision");
        left_btn = 1'b1;
        crash_wait(3'd4, 1'b1, "crash_wait_1");
        left_btn = 1'b0;
        respawn(1'b1, "respawn_1");
        for (int i = 0; i < 2; i++) begin upd_speed(); frame(1'b0, 1'b0, 1'b0, 1'b0, "run_after_respawn"); end

        car_x = 8'd0; left_btn = 1'b1;
        pulse_collision();
        e_st = 3'd3; e_lv = 2'd1; e_sp = 3'd0;
        frame(1'b1, 1'b0, 1'b0, 1'b0, "edge_plus_collision");
        car_x = 8'd120; left_btn = 1'b0;
        crash_wait(3'd4, 1'b1, "crash_wait_2");
        respawn(1'b0, "respawn_2");

        car_x = 8'd240; right_btn = 1'b1;
        e_st = 3'd3; e_lv = 2'd0; e_sp = 3'd0;
        frame(1'b0, 1'b1, 1'b0, 1'b0, "edge_right_last_life");
        car_x = 8'd120; right_btn = 1'b0;
        crash_wait(3'd5, 1'b0, "crash_to_over");
        frame(1'b0, 1'b0, 1'b0, 1'b0, "over_hold");

        start_btn = 1'b1;
        e_st = 3'd1; e_lv = 2'd3; e_over = 1'b0;
        frame(1'b0, 1'b0, 1'b1, 1'b0, "start_from_over");
        start_btn = 1'b0;
        countdown("countdown_2");

        accel_btn = 1'b1;
        for (int i = 0; i < 48 && e_sp != 3'd5; i++) begin
            upd_speed();
            frame(1'b0, 1'b0, 1'b0, 1'b0, "accel_to_5");
        end
        left_btn = 1'b1;
        do_reset("reset_mid_run");
        left_btn = 1'b0; accel_btn = 1'b0;
        frame(1'b0, 1'b0, 1'b0, 1'b0, "idle_after_reset");

        repeat (10) @(negedge clk);
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending expected entries, want 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
- Game-state sequencer for the player car.
- Sits between the raw button inputs and the `player` position register. It drives `player`'s left/right inputs with one-cycle strobes, so the car moves at 1 px per frame instead of 1 px per clock.
- Sequences start countdown, run, crash, respawn and game over, and tracks lives and scroll speed for the road/scroller blocks.
- All game-state decisions happen on the frame tick (start of vblank).

Parameters:
- START_FRAMES, 120, frames of countdown before RUN.
- CRASH_FRAMES, 90, frames the car stays frozen after a crash.
- RESPAWN_FRAMES, 60, invulnerable blinking frames after respawn.
- LIVES, 3, lives loaded at game start (max 3, 2-bit counter).
- MAX_SPEED, 7, scroll speed ceiling (3-bit).
- ACCEL_FRAMES, 8, frames between speed steps.
- X_MAX, 240, rightmost car_x (256-16).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame
- start_btn  in  1  start button, level
- left_btn  in  1  steer left, level
- right_btn  in  1  steer right, level
- accel_btn  in  1  accelerate, level
- collision  in  1  pixel-overlap hit from the renderer; may pulse at any cycle
- car_x  in  8  current car x from `player`
- move_left  out  1  one-cycle strobe to `player.left`
- move_right  out  1  one-cycle strobe to `player.right`
- recenter  out  1  one-cycle pulse; `player` position reload
- speed  out  3  scroll pixels per frame
- lives  out  2  remaining lives
- state  out  3  current FSM state
- car_visible  out  1  sprite enable (blink)
- game_over  out  1  high in OVER

Behaviour:
- Reset (reset==0 at a clk edge) has priority over everything, including mid-crash and mid-countdown. It sets:
  - state=IDLE, lives=LIVES, speed=0, frame counter=0
  - move_left=0, move_right=0, recenter=0
  - car_visible=1, game_over=0, hit flag=0
- Hit flag:
  - Set by collision on any cycle.
  - Cleared on the cycle after frame_tick.
  - crash_req = (hit flag | collision) at frame_tick.
- Edge crash: at frame_tick, (car_x==0 & left_btn & !right_btn) | (car_x==X_MAX & right_btn & !left_btn).
- Frame counter: increments on each frame_tick and is cleared on every state entry.
  - done = (count == N-1) at frame_tick, where N is the current state's duration.
- FSM states: IDLE=0, COUNTDOWN=1, RUN=2, CRASH=3, RESPAWN=4, OVER=5. Transitions are evaluated only at frame_tick.
  - IDLE: start_btn → COUNTDOWN. Pulse recenter, reload lives=LIVES.
  - COUNTDOWN: done (START_FRAMES) → RUN. Steering and speed are locked at 0.
  - RUN: crash_req or edge crash → CRASH. Set speed=0 and lives=lives-1 (saturating at 0).
    - Simultaneous collision and edge crash cause a single decrement.
  - CRASH: no steering. On done (CRASH_FRAMES):
    - lives==0 → OVER.
    - otherwise → RESPAWN, with a recenter pulse.
  - RESPAWN: steering and accel active; collision and edge crash ignored, hit flag still cleared. car_visible = ~count[3]. done (RESPAWN_FRAMES) → RUN, car_visible=1.
  - OVER: game_over=1. start_btn → COUNTDOWN, as from IDLE.
- Steering, in RUN and RESPAWN only:
  - move_left is high for exactly the one cycle after a frame_tick where left_btn & !right_btn.
  - move_right mirrors this with right_btn & !left_btn.
  - Both or neither pressed → no strobe.
  - Never more than one strobe per frame.
- Speed, in RUN and RESPAWN only: on every ACCEL_FRAMES-th tick of a free-running 3-bit accel counter:
  - accel_btn → speed+1, saturating at MAX_SPEED.
  - otherwise → speed-1, saturating at 0.
  - Speed is forced to 0 in all other states.
- Output timing:
  - recenter and strobes are registered and last 1 cycle.
  - State and other outputs update 1 cycle after frame_tick.

Decomposition:
- Shared package contents:
  - State encodings.
  - Car geometry constants: CAR_W=16, ROAD_X_MAX=240, CAR_X_RESET=120, CAR_Y=440.
  - Speed width.
- One sub-module, `frame_timer`:
  - Inputs: clear, tick, length.
  - Outputs: count, done.
  - Instantiated once and shared by all timed states.

Test Plan:
- Reset held low for 3 cycles mid-RUN with speed=5 → state=0, lives=3, speed=0, car_visible=1, all strobes 0.
- start_btn=1 at tick in IDLE → recenter 1 cycle, state=1; after 120 ticks state=2; no move strobes during countdown even with left_btn held.
- RUN, left_btn held 10 frames → exactly 10 move_left pulses, each 1 cycle wide, 0 move_right; both buttons held → 0 strobes.
- RUN, collision pulse mid-frame (not on tick) → at next tick state=3, lives 3→2, speed=0; after 90 ticks recenter pulse, state=4; car_visible toggles every 8 frames; collision ignored; after 60 ticks state=2.
- car_x=0 with left_btn at tick plus collision same frame → one crash, lives decrement by exactly 1; at lives==0, CRASH done → state=5, game_over=1; start_btn → state=1, lives=3.
- accel_btn held 64 frames in RUN → speed reaches 7 and stays; released → decrements 1 per 8 frames to 0, no wrap.
